// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad timer-entry path: key/digit geometry,
// the "no key" code, the debounce FSM state type and the priority encoder.
package keypad_pkg;

  localparam int NUM_KEYS   = 10;
  localparam int BCD_W      = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [BCD_W-1:0] NO_KEY = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    WAIT_REL = 2'd2,
    REL_DB   = 2'd3
  } key_state_t;

  // Highest set line wins; nothing pressed encodes as NO_KEY.
  function automatic logic [BCD_W-1:0] encode_key(input logic [NUM_KEYS-1:0] lines);
    logic [BCD_W-1:0] code;
    code = NO_KEY;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (lines[i]) code = BCD_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Keypad front end: 2-flop synchroniser, priority encoder and press/release
// debounce FSM. Emits a one-cycle strobe and the key code per accepted press.
// Build option: KEYPAD_MULTI_REJECT_EN -- when defined, a synchronised value
// with more than one line set is treated as invalid instead of highest-wins.
module key_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic                i_suppress,
  input  logic [NUM_KEYS-1:0] i_keypad,
  output logic                o_key_strobe,
  output logic [BCD_W-1:0]    o_key_code,
  output key_state_t          o_state
);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;

  key_state_t          r_state;
  key_state_t          w_state_nxt;
  logic [BCD_W-1:0]    r_cand;
  logic [BCD_W-1:0]    w_cand_nxt;
  logic [DB_W-1:0]     r_count;
  logic [DB_W-1:0]     w_count_nxt;
  logic                w_accept;
  logic                r_strobe;
  logic [BCD_W-1:0]    r_key_code;

  logic [BCD_W-1:0]    w_code;
  logic                w_none;
  logic                w_multi;
  logic                w_valid_key;

  assign w_code = encode_key(r_sync2);
  assign w_none = (w_code == NO_KEY);

`ifdef KEYPAD_MULTI_REJECT_EN
  assign w_multi = ((r_sync2 & (r_sync2 - NUM_KEYS'(1))) != '0);
`else
  assign w_multi = 1'b0;
`endif

  // A multi-key chord is neither a press nor a release.
  assign w_valid_key = !w_none && !w_multi;

  // Two-flop synchroniser for the raw key lines.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_keypad;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce next-state: counts matching synchronised samples per phase.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_count_nxt = r_count;
    w_accept    = 1'b0;
    if (!i_enable) begin
      w_state_nxt = IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid_key) begin
            w_state_nxt = PRESS_DB;
            w_cand_nxt  = w_code;
            w_count_nxt = DB_W'(1);
          end
        end
        PRESS_DB: begin
          if (!w_valid_key || (w_code != r_cand)) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end else if (r_count >= DB_W'(DEBOUNCE_CYCLES)) begin
            w_state_nxt = WAIT_REL;
            w_count_nxt = '0;
            w_accept    = 1'b1;
          end else begin
            w_count_nxt = r_count + DB_W'(1);
          end
        end
        WAIT_REL: begin
          if (w_none) begin
            w_state_nxt = REL_DB;
            w_count_nxt = DB_W'(1);
          end
        end
        REL_DB: begin
          if (!w_none) begin
            w_state_nxt = WAIT_REL;
            w_count_nxt = '0;
          end else if (r_count >= DB_W'(DEBOUNCE_CYCLES)) begin
            w_state_nxt = IDLE;
            w_count_nxt = '0;
          end else begin
            w_count_nxt = r_count + DB_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // FSM registers plus the strobe/code, which are withheld while suppressed
  // so the FSM still follows the release without reporting the press.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cand     <= '0;
      r_count    <= '0;
      r_strobe   <= 1'b0;
      r_key_code <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cand   <= w_cand_nxt;
      r_count  <= w_count_nxt;
      r_strobe <= w_accept && !i_suppress;
      if (w_accept && !i_suppress) r_key_code <= r_cand;
    end
  end

  assign o_key_strobe = r_strobe;
  assign o_key_code   = r_key_code;
  assign o_state      = r_state;

endmodule

// File: rtl/keypad_entry_controller.sv
// Timer-entry controller: debounced keypad presses are shifted into a 4-digit
// BCD MM:SS register and offered to the timer through a load handshake.
// Build option: KEYPAD_MULTI_REJECT_EN (see key_debouncer).
module keypad_entry_controller
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DB_W            = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enablen,
  input  logic [NUM_KEYS-1:0]         keypad,
  input  logic                        start,
  input  logic                        clear_entry,
  input  logic                        load_ack,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic [2:0]                  digit_count,
  output logic                        key_strobe,
  output logic [BCD_W-1:0]            key_code,
  output logic                        entry_full,
  output logic                        load_req,
  output key_state_t                  dbg_state
);

  logic [NUM_DIGITS*BCD_W-1:0] r_digits;
  logic [2:0]                  r_count;
  logic                        r_load_req;

  logic                        w_key_strobe;
  logic [BCD_W-1:0]            w_key_code;
  key_state_t                  w_db_state;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_key_debouncer (
    .i_clk        (clk),
    .i_rst        (reset),
    .i_enable     (!enablen),
    .i_suppress   (r_load_req),
    .i_keypad     (keypad),
    .o_key_strobe (w_key_strobe),
    .o_key_code   (w_key_code),
    .o_state      (w_db_state)
  );

  // Load handshake: load_req rises the edge after start when at least one
  // digit is held and stays high, with digits frozen, until load_ack is seen
  // while it is high; that edge drops load_req and empties the entry.
  // load_ack without load_req and start with an empty entry are ignored.
  // clear_entry beats load_ack, which beats a key shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_load_req <= 1'b0;
    end else if (clear_entry) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_load_req <= 1'b0;
    end else if (load_ack && r_load_req) begin
      r_digits   <= '0;
      r_count    <= '0;
      r_load_req <= 1'b0;
    end else begin
      if (w_key_strobe && !r_load_req && (r_count < 3'(NUM_DIGITS))) begin
        r_digits <= {r_digits[(NUM_DIGITS-1)*BCD_W-1:0], w_key_code};
        r_count  <= r_count + 3'd1;
      end
      if (start && (r_count != 3'd0) && !r_load_req) begin
        r_load_req <= 1'b1;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_count = r_count;
  assign key_strobe  = w_key_strobe;
  assign key_code    = w_key_code;
  assign entry_full  = (r_count == 3'(NUM_DIGITS));
  assign load_req    = r_load_req;
  assign dbg_state   = w_db_state;

endmodule

// File: tb/tb_keypad_entry_controller.sv
// Directed bench for keypad_entry_controller (DEBOUNCE_CYCLES = 4).
module tb_keypad_entry_controller;
  import keypad_pkg::*;

  logic        clk;
  logic        reset;
  logic        enablen;
  logic [9:0]  keypad;
  logic        start;
  logic        clear_entry;
  logic        load_ack;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic        entry_full;
  logic        load_req;
  key_state_t  dbg_state;

  int checks = 0;
  int errors = 0;

  keypad_entry_controller #(
    .DEBOUNCE_CYCLES (4),
    .DB_W            (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enablen     (enablen),
    .keypad      (keypad),
    .start       (start),
    .clear_entry (clear_entry),
    .load_ack    (load_ack),
    .digits      (digits),
    .digit_count (digit_count),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .entry_full  (entry_full),
    .load_req    (load_req),
    .dbg_state   (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: everything moves to 1 ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_mask(input logic [9:0] mask, input int hold,
                            output int n, output logic [3:0] code);
    n = 0;
    code = 4'h0;
    keypad = mask;
    repeat (hold) begin
      tick(1);
      if (key_strobe === 1'b1) begin n++; code = key_code; end
    end
    keypad = '0;
    repeat (12) begin
      tick(1);
      if (key_strobe === 1'b1) begin n++; code = key_code; end
    end
  endtask

  task automatic press(input int d, output int n, output logic [3:0] code);
    logic [9:0] m;
    m = '0;
    m[d] = 1'b1;
    press_mask(m, 10, n, code);
  endtask

  task automatic pulse_clear();
    clear_entry = 1'b1; tick(1); clear_entry = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(1); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enablen = 1'b0; keypad = '0;
    start = 1'b0; clear_entry = 1'b0; load_ack = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    checks++;
    if ({digits, digit_count, key_strobe, key_code, entry_full, load_req} !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got digits=%h cnt=%0d stb=%b code=%h full=%b req=%b expected all zero",
               digits, digit_count, key_strobe, key_code, entry_full, load_req);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE);
    end
  endtask

  task automatic test_first_key();
    keypad = 10'b0000000100;
    tick(6);   // just past edge 5
    checks++;
    if (key_strobe !== 1'b0) begin
      errors++; $display("FAIL latency_early: got stb=%b expected 0", key_strobe);
    end
    checks++;
    if (dbg_state !== PRESS_DB) begin
      errors++; $display("FAIL latency_state: got %0d expected %0d", dbg_state, PRESS_DB);
    end
    tick(1);   // just past edge 6
    checks++;
    if (key_strobe !== 1'b1 || key_code !== 4'd2) begin
      errors++; $display("FAIL latency_strobe: got stb=%b code=%h expected 1/2", key_strobe, key_code);
    end
    tick(1);
    checks++;
    if (key_strobe !== 1'b0 || digits !== 16'h0002 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL first_digit: got stb=%b digits=%h cnt=%0d expected 0/0002/1",
               key_strobe, digits, digit_count);
    end
    tick(2);
    keypad = '0;
    tick(12);
    checks++;
    if (dbg_state !== IDLE || digits !== 16'h0002) begin
      errors++; $display("FAIL first_release: got state=%0d digits=%h expected 0/0002", dbg_state, digits);
    end
  endtask

  task automatic test_sequence();
    int keys[5] = '{1, 2, 3, 0, 5};
    int n;
    logic [3:0] code;
    pulse_clear();
    for (int i = 0; i < 4; i++) begin
      press(keys[i], n, code);
      checks++;
      if (n != 1 || code !== 4'(keys[i])) begin
        errors++; $display("FAIL seq_press%0d: got n=%0d code=%h expected 1/%0d", i, n, code, keys[i]);
      end
    end
    checks++;
    if (digits !== 16'h1230 || digit_count !== 3'd4 || entry_full !== 1'b1) begin
      errors++;
      $display("FAIL seq_full: got digits=%h cnt=%0d full=%b expected 1230/4/1", digits, digit_count, entry_full);
    end
    press(keys[4], n, code);
    checks++;
    if (n != 1 || code !== 4'd5 || digits !== 16'h1230 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL seq_overflow: got n=%0d code=%h digits=%h cnt=%0d expected 1/5/1230/4",
               n, code, digits, digit_count);
    end
  endtask

  task automatic test_multi_key();
    int n;
    logic [3:0] code;
    pulse_clear();
    press_mask(10'b0010000100, 10, n, code);
`ifdef KEYPAD_MULTI_REJECT_EN
    checks++;
    if (n != 0 || digits !== 16'h0000) begin
      errors++; $display("FAIL multi_reject: got n=%0d digits=%h expected 0/0000", n, digits);
    end
`else
    checks++;
    if (n != 1 || code !== 4'd7 || digits !== 16'h0007) begin
      errors++; $display("FAIL multi_highest: got n=%0d code=%h digits=%h expected 1/7/0007", n, code, digits);
    end
`endif
  endtask

  task automatic test_bounce();
    int n;
    int n2;
    logic [3:0] code;
    logic [3:0] code2;
    pulse_clear();
    n = 0;
    code = 4'h0;
    for (int i = 0; i < 10; i++) begin
      keypad = (((i / 2) % 2) == 0) ? 10'b0000100000 : 10'b0;
      tick(1);
      if (key_strobe === 1'b1) begin n++; code = key_code; end
    end
    press_mask(10'b0000100000, 12, n2, code2);
    if (n2 > 0) code = code2;
    checks++;
    if ((n + n2) != 1 || code !== 4'd5 || digits !== 16'h0005) begin
      errors++;
      $display("FAIL bounce: got n=%0d code=%h digits=%h expected 1/5/0005", n + n2, code, digits);
    end
  endtask

  task automatic test_load();
    int n;
    logic [3:0] code;
    pulse_clear();
    pulse_start();
    checks++;
    if (load_req !== 1'b0) begin
      errors++; $display("FAIL start_empty: got req=%b expected 0", load_req);
    end
    press(4, n, code);
    press(5, n, code);
    pulse_start();
    checks++;
    if (load_req !== 1'b1 || digits !== 16'h0045 || digit_count !== 3'd2) begin
      errors++;
      $display("FAIL load_req: got req=%b digits=%h cnt=%0d expected 1/0045/2", load_req, digits, digit_count);
    end
    press(9, n, code);
    checks++;
    if (n != 0 || digits !== 16'h0045 || digit_count !== 3'd2 || key_code !== 4'd5 || load_req !== 1'b1) begin
      errors++;
      $display("FAIL load_frozen: got n=%0d digits=%h cnt=%0d code=%h req=%b expected 0/0045/2/5/1",
               n, digits, digit_count, key_code, load_req);
    end
    load_ack = 1'b1; tick(1); load_ack = 1'b0;
    checks++;
    if (load_req !== 1'b0 || digits !== 16'h0000 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL load_ack: got req=%b digits=%h cnt=%0d expected 0/0000/0", load_req, digits, digit_count);
    end
    press(7, n, code);
    load_ack = 1'b1; tick(1); load_ack = 1'b0;
    checks++;
    if (digits !== 16'h0007 || digit_count !== 3'd1 || load_req !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: got digits=%h cnt=%0d req=%b expected 0007/1/0", digits, digit_count, load_req);
    end
  endtask

  task automatic test_enable_and_clear();
    int n;
    logic [3:0] code;
    pulse_clear();
    press(3, n, code);
    enablen = 1'b1;
    press(8, n, code);
    checks++;
    if (n != 0 || digits !== 16'h0003 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL enable_off: got n=%0d digits=%h state=%0d expected 0/0003/0", n, digits, dbg_state);
    end
    enablen = 1'b0;
    pulse_start();
    clear_entry = 1'b1; load_ack = 1'b1;
    tick(1);
    clear_entry = 1'b0; load_ack = 1'b0;
    checks++;
    if (digits !== 16'h0000 || digit_count !== 3'd0 || load_req !== 1'b0) begin
      errors++;
      $display("FAIL clear_ack: got digits=%h cnt=%0d req=%b expected 0000/0/0", digits, digit_count, load_req);
    end
  endtask

  task automatic test_reset_mid_press();
    int n;
    logic [3:0] code;
    press(6, n, code);
    pulse_start();
    keypad = 10'b0000000010;
    tick(4);   // past edge 3: debouncing the press
    checks++;
    if (dbg_state !== PRESS_DB || load_req !== 1'b1 || key_code !== 4'd6) begin
      errors++;
      $display("FAIL pre_reset: got state=%0d req=%b code=%h expected 1/1/6", dbg_state, load_req, key_code);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({digits, digit_count, key_strobe, key_code, entry_full, load_req} !== 26'd0 || dbg_state !== IDLE) begin
      errors++;
      $display("FAIL async_reset: got digits=%h cnt=%0d stb=%b code=%h req=%b state=%0d expected all zero",
               digits, digit_count, key_strobe, key_code, load_req, dbg_state);
    end
    #2 reset = 1'b0;
    press_mask(10'b0000000010, 12, n, code);
    checks++;
    if (n != 1 || code !== 4'd1 || digits !== 16'h0001) begin
      errors++;
      $display("FAIL post_reset_press: got n=%0d code=%h digits=%h expected 1/1/0001", n, code, digits);
    end
  endtask

  // Scenario sequence and final report
  initial begin
    test_reset();
    test_first_key();
    test_sequence();
    test_multi_key();
    test_bounce();
    test_load();
    test_enable_and_clear();
    test_reset_mid_press();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
